// File: rtl/time_set_ctrl.sv
// Time-setting sequencer for the digital clock: RUN -> SET_HR -> SET_MIN -> RUN on the mode
// button, with increment pulses to the selected field, inactivity timeout, hold-to-repeat and blink.
module time_set_ctrl #(
    parameter int unsigned TIMEOUT_S = 10,
    parameter int unsigned REPEAT_S  = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       mode_btn,
    input  logic       inc_btn,
    output logic       sel,
    output logic       inc_pulse,
    output logic       set_active,
    output logic       blink,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_SET_HR  = 2'b01,
        ST_SET_MIN = 2'b10,
        ST_BAD     = 2'b11
    } state_t;

    localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT_S - 1);
    localparam logic [3:0] HOLD_MAX  = 4'(REPEAT_S);
    localparam logic [3:0] HOLD_LAST = 4'(REPEAT_S - 1);

    state_t      state_r, state_nxt_s;
    logic        sel_r, pulse_r, active_r, blink_r;
    logic        mode_q_r, inc_q_r, armed_r, pend_r;
    logic [7:0]  idle_r, idle_nxt_s;
    logic [3:0]  hold_r, hold_nxt_s;
    logic        mode_rise_s, inc_rise_s, in_set_s, timeout_s, chg_s;
    logic        pend_nxt_s, pulse_nxt_s, blink_nxt_s;

    function automatic state_t next_field(input state_t cur);
        case (cur)
            ST_RUN:     return ST_SET_HR;
            ST_SET_HR:  return ST_SET_MIN;
            ST_SET_MIN: return ST_RUN;
            default:    return ST_RUN;
        endcase
    endfunction

    // Next-state, increment, hold, idle and blink decisions for the coming edge.
    always_comb begin
        // armed_r masks the first cycle after reset so a button held through release gives no edge
        mode_rise_s = mode_btn & ~mode_q_r & armed_r;
        inc_rise_s  = inc_btn & ~inc_q_r & armed_r;
        in_set_s    = (state_r == ST_SET_HR) || (state_r == ST_SET_MIN);
        timeout_s   = in_set_s & tick_1hz & ~inc_rise_s & (idle_r == IDLE_LAST);
        state_nxt_s = state_r;
        pend_nxt_s  = 1'b0;

        // A simultaneous mode+inc edge in a set state defers the advance one clk so the
        // increment pulse still sees the old sel.
        if (state_r == ST_BAD) begin
            state_nxt_s = ST_RUN;
        end else if (pend_r) begin
            state_nxt_s = next_field(state_r);
        end else if (mode_rise_s) begin
            if (in_set_s && inc_rise_s) begin
                pend_nxt_s = 1'b1;
            end else begin
                state_nxt_s = next_field(state_r);
            end
        end else if (timeout_s) begin
            state_nxt_s = ST_RUN;
        end else begin
            state_nxt_s = state_r;
        end

        chg_s = (state_nxt_s != state_r);

        if (in_set_s && inc_rise_s) begin
            pulse_nxt_s = 1'b1;
        end else if (in_set_s && !chg_s && tick_1hz && inc_btn && (hold_r >= HOLD_LAST)) begin
            pulse_nxt_s = 1'b1;
        end else begin
            pulse_nxt_s = 1'b0;
        end

        if (chg_s || !inc_btn || inc_rise_s) begin
            hold_nxt_s = 4'd0;
        end else if (tick_1hz && (hold_r < HOLD_MAX)) begin
            hold_nxt_s = hold_r + 4'd1;
        end else begin
            hold_nxt_s = hold_r;
        end

        if (chg_s || mode_rise_s || inc_rise_s || !in_set_s) begin
            idle_nxt_s = 8'd0;
        end else if (tick_1hz) begin
            idle_nxt_s = idle_r + 8'd1;
        end else begin
            idle_nxt_s = idle_r;
        end

        if (state_nxt_s == ST_RUN) begin
            blink_nxt_s = 1'b0;
        end else if (chg_s) begin
            blink_nxt_s = 1'b1;
        end else if (tick_1hz) begin
            blink_nxt_s = ~blink_r;
        end else begin
            blink_nxt_s = blink_r;
        end
    end

    // State, counters, edge-detect history and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r  <= ST_RUN;
            sel_r    <= 1'b0;
            pulse_r  <= 1'b0;
            active_r <= 1'b0;
            blink_r  <= 1'b0;
            mode_q_r <= 1'b0;
            inc_q_r  <= 1'b0;
            armed_r  <= 1'b0;
            pend_r   <= 1'b0;
            idle_r   <= 8'd0;
            hold_r   <= 4'd0;
        end else begin
            state_r  <= state_nxt_s;
            sel_r    <= (state_nxt_s == ST_SET_HR);
            pulse_r  <= pulse_nxt_s;
            active_r <= (state_nxt_s == ST_SET_HR) || (state_nxt_s == ST_SET_MIN);
            blink_r  <= blink_nxt_s;
            mode_q_r <= mode_btn;
            inc_q_r  <= inc_btn;
            armed_r  <= 1'b1;
            pend_r   <= pend_nxt_s;
            idle_r   <= idle_nxt_s;
            hold_r   <= hold_nxt_s;
        end
    end

    assign state      = state_r;
    assign sel        = sel_r;
    assign inc_pulse  = pulse_r;
    assign set_active = active_r;
    assign blink      = blink_r;

endmodule

// File: tb/tb_time_set_ctrl.sv
// Self-checking bench for time_set_ctrl: directed scenarios plus randomized buttons/ticks
// compared every cycle against a behavioural model of the time-setting rules.
module tb_time_set_ctrl;

    localparam int TIMEOUT_S = 10;
    localparam int REPEAT_S  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       mode_btn = 1'b0;
    logic       inc_btn = 1'b0;
    logic       sel, inc_pulse, set_active, blink;
    logic [1:0] state;
    logic [5:0] dut_o;
    logic [5:0] exp_o;

    int checks = 0;
    int errors = 0;
    int p_hr = 0;
    int p_min = 0;

    // model: field as 0=RUN,1=HR,2=MIN, elapsed-seconds counters, last button levels
    int m_mode, m_idle, m_hold, m_nxt;
    bit m_pend, m_mprev, m_iprev, m_armed, m_blink;
    bit m_mr, m_ir, m_set, m_pulse;

    time_set_ctrl #(.TIMEOUT_S(TIMEOUT_S), .REPEAT_S(REPEAT_S)) dut (
        .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .mode_btn(mode_btn), .inc_btn(inc_btn),
        .sel(sel), .inc_pulse(inc_pulse), .set_active(set_active), .blink(blink), .state(state)
    );

    assign dut_o = {state, sel, inc_pulse, set_active, blink};

    always #5 clk = ~clk;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode = 0; m_idle = 0; m_hold = 0; m_pend = 0;
            m_mprev = 0; m_iprev = 0; m_armed = 0; m_blink = 0;
            exp_o = 6'd0;
        end else begin
            m_mr  = mode_btn && !m_mprev && m_armed;
            m_ir  = inc_btn && !m_iprev && m_armed;
            m_set = (m_mode != 0);
            m_nxt = m_mode;
            if (m_pend) begin
                m_nxt = (m_mode + 1) % 3;
                m_pend = 0;
            end else if (m_mr && m_set && m_ir) m_pend = 1;
            else if (m_mr) m_nxt = (m_mode + 1) % 3;
            else if (m_set && tick_1hz && !m_ir && (m_idle + 1 >= TIMEOUT_S)) m_nxt = 0;
            m_pulse = m_set && (m_ir || (tick_1hz && inc_btn && m_nxt == m_mode && m_hold + 1 >= REPEAT_S));
            if (m_nxt != m_mode || !inc_btn || m_ir) m_hold = 0;
            else if (tick_1hz && m_hold < REPEAT_S) m_hold++;
            if (m_nxt == 0 || m_nxt != m_mode || m_mr || m_ir) m_idle = 0;
            else if (tick_1hz) m_idle++;
            if (m_nxt == 0) m_blink = 0;
            else if (m_nxt != m_mode) m_blink = 1;
            else if (tick_1hz) m_blink = !m_blink;
            m_mode = m_nxt; m_mprev = mode_btn; m_iprev = inc_btn; m_armed = 1;
            exp_o = {2'(m_nxt), (m_nxt == 1), m_pulse, (m_nxt != 0), m_blink};
        end
    end

    always @(posedge clk) begin
        #1;
        if (!rst && inc_pulse === 1'b1) begin
            if (sel) p_hr++;
            else p_min++;
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic tick_once();
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0; step(2);
    endtask

    task automatic press_mode();
        mode_btn = 1'b1; step(5); mode_btn = 1'b0; step(1);
    endtask

    task automatic press_inc();
        inc_btn = 1'b1; step(3); inc_btn = 1'b0; step(2);
    endtask

    task automatic test_reset();
        int base;
        rst = 1'b1; step(2);
        checks++; if (dut_o !== 6'd0) begin errors++; $display("FAIL reset_hold: got %b want 000000", dut_o); end
        rst = 1'b0; step(2);
        press_mode(); press_mode();
        checks++; if (state !== 2'b10) begin errors++; $display("FAIL reach_set_min: state %b want 10", state); end
        inc_btn = 1'b1; step(2);
        rst = 1'b1; #1;
        checks++; if (dut_o !== 6'd0) begin errors++; $display("FAIL async_reset: got %b want 000000", dut_o); end
        step(2);
        rst = 1'b0; base = p_hr + p_min; step(4);
        checks++; if (p_hr + p_min != base) begin errors++; $display("FAIL held_inc_after_reset: pulses %0d want 0", p_hr + p_min - base); end
        press_mode();
        checks++; if (state !== 2'b01 || p_hr + p_min != base) begin
            errors++; $display("FAIL enter_hr_inc_held: state %b pulses %0d want 01/0", state, p_hr + p_min - base); end
        inc_btn = 1'b0; step(1); press_mode(); press_mode();
        checks++; if (dut_o !== exp_o || state !== 2'b00) begin errors++; $display("FAIL reset_back_run: got %b want %b", dut_o, exp_o); end
    endtask

    task automatic test_mode_cycle();
        logic [1:0] prev;
        int chg;
        logic [1:0] want_st [3];
        logic       want_sel [3];
        logic       want_act [3];
        want_st  = '{2'b01, 2'b10, 2'b00};
        want_sel = '{1'b1, 1'b0, 1'b0};
        want_act = '{1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 3; i++) begin
            prev = state; chg = 0; mode_btn = 1'b1;
            for (int k = 0; k < 5; k++) begin
                step(1);
                if (state !== prev) chg++;
                prev = state;
            end
            mode_btn = 1'b0; step(1);
            if (state !== prev) chg++;
            checks++; if (state !== want_st[i] || sel !== want_sel[i] || set_active !== want_act[i]) begin
                errors++; $display("FAIL mode_press%0d: st/sel/act %b/%b/%b want %b/%b/%b", i, state, sel, set_active, want_st[i], want_sel[i], want_act[i]); end
            checks++; if (chg != 1) begin errors++; $display("FAIL mode_press%0d_transitions: got %0d want 1", i, chg); end
        end
    endtask

    task automatic test_single_inc();
        int hr0, mn0;
        press_mode();
        hr0 = p_hr; mn0 = p_min;
        inc_btn = 1'b1; step(1);
        checks++; if (inc_pulse !== 1'b1 || sel !== 1'b1) begin errors++; $display("FAIL inc_hr_latency: pulse %b sel %b want 1/1", inc_pulse, sel); end
        step(1);
        checks++; if (inc_pulse !== 1'b0) begin errors++; $display("FAIL inc_hr_width: pulse %b want 0", inc_pulse); end
        inc_btn = 1'b0; step(2);
        checks++; if (p_hr - hr0 != 1 || p_min != mn0) begin errors++; $display("FAIL inc_hr_count: hr %0d min %0d want 1/0", p_hr - hr0, p_min - mn0); end
        press_mode();
        hr0 = p_hr; mn0 = p_min;
        press_inc();
        checks++; if (p_min - mn0 != 1 || p_hr != hr0) begin errors++; $display("FAIL inc_min_count: hr %0d min %0d want 0/1", p_hr - hr0, p_min - mn0); end
        press_mode();
        hr0 = p_hr; mn0 = p_min;
        press_inc();
        checks++; if (p_hr + p_min != hr0 + mn0 || state !== 2'b00) begin errors++; $display("FAIL inc_in_run: pulses %0d state %b want 0/00", p_hr + p_min - hr0 - mn0, state); end
    endtask

    task automatic test_auto_repeat();
        int hr0, mn0;
        press_mode(); press_mode();
        hr0 = p_hr; mn0 = p_min;
        inc_btn = 1'b1; step(1);
        for (int t = 0; t < 6; t++) tick_once();
        checks++; if (p_min - mn0 != 6 || p_hr != hr0) begin errors++; $display("FAIL repeat_count: min %0d hr %0d want 6/0", p_min - mn0, p_hr - hr0); end
        inc_btn = 1'b0; step(1); tick_once();
        checks++; if (p_min - mn0 != 6) begin errors++; $display("FAIL repeat_after_release: min %0d want 6", p_min - mn0); end
        checks++; if (dut_o !== exp_o) begin errors++; $display("FAIL repeat_model: got %b want %b", dut_o, exp_o); end
        press_mode();
    endtask

    task automatic test_timeout();
        press_mode();
        for (int t = 1; t < TIMEOUT_S; t++) tick_once();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL timeout_early: state %b want 01", state); end
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
        checks++; if (state !== 2'b00 || set_active !== 1'b0 || blink !== 1'b0) begin
            errors++; $display("FAIL timeout_edge: st/act/blink %b/%b/%b want 00/0/0", state, set_active, blink); end
        step(2); press_mode();
        for (int t = 1; t <= 7; t++) tick_once();
        press_inc();
        for (int t = 8; t < 17; t++) tick_once();
        checks++; if (state !== 2'b01) begin errors++; $display("FAIL timeout_restart_early: state %b want 01", state); end
        tick_1hz = 1'b1; step(1); tick_1hz = 1'b0;
        checks++; if (state !== 2'b00) begin errors++; $display("FAIL timeout_restart_edge: state %b want 00", state); end
        step(2);
    endtask

    task automatic test_simultaneous();
        press_mode();
        mode_btn = 1'b1; inc_btn = 1'b1; step(1);
        checks++; if (inc_pulse !== 1'b1 || sel !== 1'b1 || state !== 2'b01) begin
            errors++; $display("FAIL simul_pulse: pulse/sel/st %b/%b/%b want 1/1/01", inc_pulse, sel, state); end
        step(1);
        checks++; if (state !== 2'b10 || sel !== 1'b0 || inc_pulse !== 1'b0) begin
            errors++; $display("FAIL simul_advance: st/sel/pulse %b/%b/%b want 10/0/0", state, sel, inc_pulse); end
        mode_btn = 1'b0; inc_btn = 1'b0; step(2);
        press_mode(); press_mode();
        for (int t = 1; t < TIMEOUT_S; t++) tick_once();
        tick_1hz = 1'b1; mode_btn = 1'b1; step(1); tick_1hz = 1'b0;
        checks++; if (state !== 2'b10 || blink !== 1'b1) begin errors++; $display("FAIL mode_beats_timeout: st %b blink %b want 10/1", state, blink); end
        mode_btn = 1'b0; step(1); press_mode();
        checks++; if (dut_o !== exp_o) begin errors++; $display("FAIL simul_model: got %b want %b", dut_o, exp_o); end
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            tick_1hz = ($urandom_range(3) == 0);
            if ($urandom_range(39) == 0) mode_btn = ~mode_btn;
            if ($urandom_range(7) == 0) inc_btn = ~inc_btn;
            step(1);
            checks++;
            if (dut_o !== exp_o) begin
                errors++;
                $display("FAIL random cyc %0d: dut %b model %b", c, dut_o, exp_o);
            end
        end
        tick_1hz = 1'b0; mode_btn = 1'b0; inc_btn = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode_cycle();
        test_single_inc();
        test_auto_repeat();
        test_timeout();
        test_simultaneous();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end

endmodule
